// File: rtl/tlul_slave_mem_if.sv
// TileLink-UL channel A/D bundle between a requester (master) and a responder (slave).
interface tlul_slave_mem_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int SOURCE_W = 4,
  parameter int SIZE_W   = 2
);
  localparam int NB = DATA_W / 8;

  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [SIZE_W-1:0]   a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [NB-1:0]       a_mask;
  logic [DATA_W-1:0]   a_data;

  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [SIZE_W-1:0]   d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_sink;
  logic [DATA_W-1:0]   d_data;
  logic                d_error;

  // A beat transfers on an edge where a_valid && a_ready; D likewise with d_valid && d_ready.
  // A raised valid is held, with its payload stable, until the transfer edge.
  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );
endinterface

// File: rtl/tlul_slave_mem.sv
// TileLink-UL responder over a small word memory: one outstanding request,
// response delivered LATENCY edges after accept, bad requests answered with d_error.
module tlul_slave_mem #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 16,
  parameter int SOURCE_W = 4,
  parameter int SIZE_W   = 2,
  parameter int LATENCY  = 1
) (
  input  logic            clk,
  input  logic            reset,
  tlul_slave_mem_if.slave tl,
  output logic [1:0]      dbg_state_o
);
  localparam int NB     = DATA_W / 8;
  localparam int OFF    = $clog2(NB);
  localparam int IDX_W  = ADDR_W - OFF;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          d_opcode_q;
  logic [SIZE_W-1:0]   d_size_q;
  logic [SOURCE_W-1:0] d_source_q;
  logic [DATA_W-1:0]   d_data_q;
  logic                d_error_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [IDX_W-1:0]    idx;
  logic [MEM_AW-1:0]   mem_idx;
  logic [ADDR_W-1:0]   align_mask;
  logic                op_put, op_get, err, accept, fire;
  logic                unused_a_param;

  assign idx        = tl.a_address[ADDR_W-1:OFF];
  assign mem_idx    = idx[MEM_AW-1:0];
  assign align_mask = (ADDR_W'(1) << tl.a_size) - ADDR_W'(1);
  assign op_put     = (tl.a_opcode == 3'd0) || (tl.a_opcode == 3'd1);
  assign op_get     = (tl.a_opcode == 3'd4);
  assign err        = (32'(idx) >= DEPTH) || !(op_put || op_get) ||
                      (32'(tl.a_size) > OFF) || ((tl.a_address & align_mask) != '0);
  assign accept     = tl.a_valid && tl.a_ready;
  assign fire       = tl.d_valid && tl.d_ready;
  assign unused_a_param = ^tl.a_param;

  // a_ready is gated by reset so it stays low for the whole reset pulse.
  assign tl.a_ready  = (state_q == ST_IDLE) && !reset;
  assign tl.d_valid  = (state_q == ST_RESP);
  assign tl.d_opcode = d_opcode_q;
  assign tl.d_param  = 2'd0;
  assign tl.d_size   = d_size_q;
  assign tl.d_source = d_source_q;
  assign tl.d_sink   = 1'b0;
  assign tl.d_data   = d_data_q;
  assign tl.d_error  = d_error_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: begin
        if (fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response fields and the memory write are both captured on the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept) begin
      d_opcode_q <= op_get ? 3'd1 : 3'd0;
      d_size_q   <= tl.a_size;
      d_source_q <= tl.a_source;
      d_error_q  <= err;
      d_data_q   <= (op_get && !err) ? mem_q[mem_idx] : '0;
      if (op_put && !err) begin
        for (int b = 0; b < NB; b++) begin
          if (tl.a_mask[b]) mem_q[mem_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_tlul_slave_mem.sv
// Bench for tlul_slave_mem: a LATENCY=1 and a LATENCY=3 instance behind one request driver,
// with a word-memory model feeding an expected-response queue.
module tb_tlul_slave_mem;
  localparam int RSP_W = 42;  // {opcode[3], size[2], source[4], error, data[32]}

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid, d_ready, sel3;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [3:0]  a_source, a_mask;
  logic [7:0]  a_address;
  logic [31:0] a_data;
  logic [1:0]  dbg1, dbg3;

  tlul_slave_mem_if #(.DATA_W(32), .ADDR_W(8), .SOURCE_W(4), .SIZE_W(2)) if1 ();
  tlul_slave_mem_if #(.DATA_W(32), .ADDR_W(8), .SOURCE_W(4), .SIZE_W(2)) if3 ();

  assign if1.a_valid = a_valid & ~sel3;
  assign if3.a_valid = a_valid & sel3;
  assign if1.a_opcode = a_opcode;   assign if3.a_opcode = a_opcode;
  assign if1.a_param = a_param;     assign if3.a_param = a_param;
  assign if1.a_size = a_size;       assign if3.a_size = a_size;
  assign if1.a_source = a_source;   assign if3.a_source = a_source;
  assign if1.a_address = a_address; assign if3.a_address = a_address;
  assign if1.a_mask = a_mask;       assign if3.a_mask = a_mask;
  assign if1.a_data = a_data;       assign if3.a_data = a_data;
  assign if1.d_ready = d_ready;     assign if3.d_ready = d_ready;

  tlul_slave_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .SOURCE_W(4), .SIZE_W(2), .LATENCY(1))
    dut1 (.clk(clk), .reset(reset), .tl(if1), .dbg_state_o(dbg1));
  tlul_slave_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .SOURCE_W(4), .SIZE_W(2), .LATENCY(3))
    dut3 (.clk(clk), .reset(reset), .tl(if3), .dbg_state_o(dbg3));

  logic        obs_a_ready, obs_d_valid, obs_d_sink, obs_d_error;
  logic [2:0]  obs_d_opcode;
  logic [1:0]  obs_d_param, obs_d_size, obs_dbg;
  logic [3:0]  obs_d_source;
  logic [31:0] obs_d_data;
  assign obs_a_ready  = sel3 ? if3.a_ready  : if1.a_ready;
  assign obs_d_valid  = sel3 ? if3.d_valid  : if1.d_valid;
  assign obs_d_opcode = sel3 ? if3.d_opcode : if1.d_opcode;
  assign obs_d_param  = sel3 ? if3.d_param  : if1.d_param;
  assign obs_d_size   = sel3 ? if3.d_size   : if1.d_size;
  assign obs_d_source = sel3 ? if3.d_source : if1.d_source;
  assign obs_d_sink   = sel3 ? if3.d_sink   : if1.d_sink;
  assign obs_d_data   = sel3 ? if3.d_data   : if1.d_data;
  assign obs_d_error  = sel3 ? if3.d_error  : if1.d_error;
  assign obs_dbg      = sel3 ? dbg3 : dbg1;

  logic [RSP_W-1:0] exp_q[$];
  logic [31:0]      model_mem [2][16];
  int               n_cmp = 0;
  int               n_bad = 0;

  function automatic logic [RSP_W-1:0] obs_rsp();
    return {obs_d_opcode, obs_d_size, obs_d_source, obs_d_error, obs_d_data};
  endfunction

  task automatic clear_model();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++) model_mem[m][i] = 32'h0;
    exp_q.delete();
  endtask

  // Drive one request (called at a negedge); on accept, push the expected response.
  task automatic send(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [1:0] size, input logic [3:0] src);
    int          idx, m, n;
    logic        err;
    logic [31:0] rdata;
    idx = int'(addr >> 2);
    m   = sel3 ? 1 : 0;
    err = (idx >= 16) || !(op == 3'd0 || op == 3'd1 || op == 3'd4) || (size > 2'd2) ||
          ((addr & ((8'd1 << size) - 8'd1)) != 8'd0);
    rdata = (op == 3'd4 && !err) ? model_mem[m][idx] : 32'h0;
    a_valid = 1'b1; a_opcode = op; a_param = 3'd0; a_size = size;
    a_source = src; a_address = addr; a_mask = mask; a_data = data;
    n = 0;
    while (!obs_a_ready && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (obs_a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_timeout: a_ready=%b required 1", obs_a_ready);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back({(op == 3'd4) ? 3'd1 : 3'd0, size, src, err, rdata});
    if ((op == 3'd0 || op == 3'd1) && !err)
      for (int b = 0; b < 4; b++)
        if (mask[b]) model_mem[m][idx][8*b +: 8] = data[8*b +: 8];
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  // Wait for a D beat, compare it to the queue head, let it fire, check the idle return.
  task automatic recv(input string tag);
    int               n;
    logic [RSP_W-1:0] got, exp;
    n = 0;
    while (!obs_d_valid && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (obs_d_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout: d_valid=%b required 1", tag, obs_d_valid);
      return;
    end
    got = obs_rsp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : {RSP_W{1'bx}};
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s_rsp: got op=%0d sz=%0d src=%0d err=%b data=%h required op=%0d sz=%0d src=%0d err=%b data=%h",
               tag, got[41:39], got[38:37], got[36:33], got[32], got[31:0],
               exp[41:39], exp[38:37], exp[36:33], exp[32], exp[31:0]);
    end
    n_cmp++;
    if (obs_d_param !== 2'd0 || obs_d_sink !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_const: d_param=%0d d_sink=%b required 0 0", tag, obs_d_param, obs_d_sink);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs_a_ready !== 1'b1 || obs_d_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_after_fire: a_ready=%b d_valid=%b required 1 0", tag, obs_a_ready, obs_d_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (if1.a_ready !== 1'b0 || if3.a_ready !== 1'b0 || if1.d_valid !== 1'b0 || if3.d_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs: a_ready=%b/%b d_valid=%b/%b required 0", if1.a_ready, if3.a_ready, if1.d_valid, if3.d_valid);
    end
    n_cmp++;
    if (obs_rsp() !== {RSP_W{1'b0}} || dbg1 !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_fields: d=%h state=%0d required 0 0", obs_rsp(), dbg1);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (if1.a_ready !== 1'b1 || if3.a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: a_ready=%b/%b required 1", if1.a_ready, if3.a_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_put_get();
    sel3 = 1'b0;
    send(3'd4, 8'h20, 32'h0, 4'hF, 2'd2, 4'd1);              recv("fresh_get");
    send(3'd0, 8'h08, 32'hDEADBEEF, 4'hF, 2'd2, 4'd3);       recv("put_full");
    send(3'd4, 8'h08, 32'h0, 4'h0, 2'd2, 4'd3);              recv("get_full");
  endtask

  task automatic test_partial();
    sel3 = 1'b0;
    send(3'd0, 8'h04, 32'h11223344, 4'hF, 2'd2, 4'd2);       recv("pre_write");
    send(3'd1, 8'h04, 32'hAABBCCDD, 4'h5, 2'd2, 4'd2);       recv("put_partial");
    send(3'd4, 8'h04, 32'h0, 4'hF, 2'd2, 4'd7);              recv("get_partial");
    n_cmp++;
    if (model_mem[0][1] !== 32'h11BB33DD) begin
      n_bad++;
      $display("FAIL partial_model: model=%h required 11bb33dd", model_mem[0][1]);
    end
  endtask

  task automatic test_errors();
    sel3 = 1'b0;
    send(3'd4, 8'h40, 32'h0, 4'hF, 2'd2, 4'd4);              recv("err_range");
    send(3'd0, 8'h41, 32'hFFFFFFFF, 4'hF, 2'd2, 4'd5);       recv("err_put_range");
    send(3'd0, 8'h06, 32'hFFFFFFFF, 4'hF, 2'd2, 4'd6);       recv("err_misalign");
    send(3'd0, 8'h04, 32'hFFFFFFFF, 4'hF, 2'd3, 4'd6);       recv("err_size");
    send(3'd2, 8'h08, 32'hFFFFFFFF, 4'hF, 2'd2, 4'd9);       recv("err_opcode");
    send(3'd4, 8'h04, 32'h0, 4'hF, 2'd2, 4'd8);              recv("readback_04");
    send(3'd4, 8'h08, 32'h0, 4'hF, 2'd2, 4'd8);              recv("readback_08");
  endtask

  task automatic test_backpressure();
    int               n;
    logic [RSP_W-1:0] held;
    sel3 = 1'b0;
    d_ready = 1'b0;
    send(3'd4, 8'h08, 32'h0, 4'hF, 2'd2, 4'd11);
    n = 0;
    while (!obs_d_valid && n < 20) begin @(negedge clk); n++; end
    held = obs_rsp();
    // A competing request while busy must be ignored, not queued.
    a_valid = 1'b1; a_opcode = 3'd0; a_address = 8'h08; a_data = 32'h0BADF00D;
    a_mask = 4'hF; a_size = 2'd2; a_source = 4'd12;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_d_valid !== 1'b1 || obs_a_ready !== 1'b0 || obs_rsp() !== held) begin
        n_bad++;
        $display("FAIL bp_hold%0d: d_valid=%b a_ready=%b d=%h required 1 0 %h",
                 c, obs_d_valid, obs_a_ready, obs_rsp(), held);
      end
    end
    a_valid = 1'b0;
    d_ready = 1'b1;
    recv("bp_release");
    send(3'd4, 8'h08, 32'h0, 4'hF, 2'd2, 4'd13);             recv("bp_readback");
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [1:0] size;
    int         idx, off;
    sel3 = 1'b0;
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 2))
        0:       op = 3'd0;
        1:       op = 3'd1;
        default: op = 3'd4;
      endcase
      idx  = $urandom_range(0, 17);
      size = 2'($urandom_range(0, 2));
      off  = $urandom_range(0, 3) & ~((1 << size) - 1);
      send(op, 8'(idx * 4 + off), $urandom, 4'($urandom_range(0, 15)), size, 4'($urandom_range(0, 15)));
      recv("b2b");
    end
  endtask

  task automatic test_latency3();
    sel3 = 1'b1;
    send(3'd0, 8'h10, 32'hCAFEF00D, 4'hF, 2'd2, 4'd5);
    n_cmp++;
    if (obs_d_valid !== 1'b0 || obs_dbg !== 2'd1) begin
      n_bad++;
      $display("FAIL lat3_k0: d_valid=%b state=%0d required 0 1", obs_d_valid, obs_dbg);
    end
    @(negedge clk);
    n_cmp++;
    if (obs_d_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL lat3_k1: d_valid=%b required 0", obs_d_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (obs_d_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL lat3_k2: d_valid=%b required 1", obs_d_valid);
    end
    recv("lat3_put");
    send(3'd4, 8'h10, 32'h0, 4'hF, 2'd2, 4'd6);              recv("lat3_get");
    send(3'd2, 8'h10, 32'h0, 4'hF, 2'd2, 4'd7);              recv("lat3_badop");
  endtask

  task automatic test_reset_mid();
    int seen;
    sel3 = 1'b1;
    send(3'd0, 8'h0C, 32'h55AA55AA, 4'hF, 2'd2, 4'd2);
    n_cmp++;
    if (obs_dbg !== 2'd1) begin
      n_bad++;
      $display("FAIL rst_mid_state: state=%0d required 1", obs_dbg);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs_a_ready !== 1'b0 || obs_d_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_assert: a_ready=%b d_valid=%b required 0 0", obs_a_ready, obs_d_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (obs_d_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0 || obs_a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_drop: d_beats=%0d a_ready=%b required 0 1", seen, obs_a_ready);
    end
    send(3'd4, 8'h0C, 32'h0, 4'hF, 2'd2, 4'd3);              recv("rst_mid_get");
    sel3 = 1'b0;
    send(3'd4, 8'h08, 32'h0, 4'hF, 2'd2, 4'd3);              recv("rst_mem_clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_valid = 1'b0; d_ready = 1'b1; sel3 = 1'b0;
    a_opcode = 3'd0; a_param = 3'd0; a_size = 2'd0; a_source = 4'd0;
    a_address = 8'h0; a_mask = 4'h0; a_data = 32'h0;
    clear_model();
    repeat (2) @(negedge clk);
    test_reset();
    test_put_get();
    test_partial();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_latency3();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: queue=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlul_slave_mem.md
Name: tlul_slave_mem

Overview:
TileLink-UL responder (device end) backed by a small register-file memory; it is the counterpart the tlulMaster bench drives against.
- Accepts Get, PutFullData and PutPartialData on channel A.
- Returns AccessAck / AccessAckData on channel D after a programmable latency.
- Supports one outstanding transaction; out-of-range or illegal requests are flagged with d_error.

Parameters:
DATA_W, 32, data bus width in bits (multiple of 8, power of 2); byte lanes NB = DATA_W/8, OFF = log2(NB)
ADDR_W, 8, byte address width
DEPTH, 16, number of DATA_W words implemented (DEPTH <= 2^(ADDR_W-OFF))
SOURCE_W, 4, source ID width
SIZE_W, 2, size field width (log2 bytes)
LATENCY, 1, clock edges from accept to d_valid rising (>= 1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
a_valid  input  1  channel A request valid
a_ready  output  1  channel A ready
a_opcode  input  3  0=PutFullData, 1=PutPartialData, 4=Get
a_param  input  3  ignored (must be 0)
a_size  input  SIZE_W  log2 transfer bytes
a_source  input  SOURCE_W  requester ID
a_address  input  ADDR_W  byte address
a_mask  input  NB  byte-lane enables
a_data  input  DATA_W  write data
d_valid  output  1  channel D response valid
d_ready  input  1  channel D ready
d_opcode  output  3  0=AccessAck, 1=AccessAckData
d_param  output  2  always 0
d_size  output  SIZE_W  echo of a_size
d_source  output  SOURCE_W  echo of a_source
d_sink  output  1  always 0
d_data  output  DATA_W  read data (0 for writes and errors)
d_error  output  1  request failed

Behaviour:
- Reset (async assert):
  - State = IDLE; a_ready=0 while reset is high, 1 on the first edge-free cycle after release.
  - d_valid=0; d_opcode, d_size, d_source, d_data, d_error = 0.
  - All memory words = 0.
- Reset mid-transaction: the pending response is discarded; no D beat appears after release.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: a_ready=1. Accept on a_valid && a_ready → WAIT with cnt=LATENCY-1, or RESP directly if LATENCY==1.
  - WAIT: a_ready=0; cnt decrements each edge; the edge where cnt==1 → RESP (d_valid rises).
  - RESP: d_valid=1, a_ready=0. Fire on d_valid && d_ready → IDLE. a_ready returns 1 the cycle after the fire; no same-cycle re-accept.
- Timing: with LATENCY=N, d_valid is high in the cycle following the Nth rising edge after the accept edge. Peak throughput is 1 transaction per N+1 cycles.
- D fields are registered at the accept edge and held stable while d_valid && !d_ready.
- Decode at accept: idx = a_address[ADDR_W-1:OFF].
- err = any of:
  - idx >= DEPTH
  - a_opcode not in {0,1,4}
  - a_size > OFF
  - a_address not aligned to 2^a_size
- Write (opcode 0 or 1, !err): at the accept edge, mem[idx] byte b takes a_data byte b for every b with a_mask[b]=1; other bytes unchanged. PutFullData and PutPartialData are treated identically. Response: d_opcode=0, d_data=0.
- Get (!err): d_data = mem[idx] sampled at the accept edge, all lanes returned regardless of a_mask. d_opcode=1.
- Error: no memory update; d_error=1; d_data=0. d_opcode is still 1 for Get, 0 for Put, 0 for an unsupported opcode.
- Echo: d_size=a_size, d_source=a_source. d_param=0, d_sink=0.
- a_valid while a_ready=0 has no effect; requests are never queued.

Test Plan:
- PutFullData addr 0x08, data 0xDEADBEEF, mask 0xF, size 2, source 3 → one beat: d_opcode=0, d_source=3, d_error=0. Then Get 0x08 → d_opcode=1, d_data=0xDEADBEEF.
- Prior write 0x11223344 at 0x04; PutPartialData 0x04, data 0xAABBCCDD, mask 0x5 → Get 0x04 returns 0x11BB33DD.
- Get 0x40 (idx 16 >= DEPTH), then Put to 0x41 with size 2 (misaligned) → d_error=1, d_data=0 for both; memory unchanged on readback.
- d_ready held low 5 cycles in RESP → d_valid stays 1 and all D fields stable; a_ready=0 throughout. After the fire, a_ready=1 the next cycle.
- LATENCY=3: accept at edge k → d_valid first sampled high at edge k+3 and not before. a_opcode=2 → d_error=1.
- Assert reset while in WAIT after a Put to 0x0C → no D beat after release, a_ready=1, Get 0x0C returns 0.
